// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared encodings for the MIPS core front end: decoder branch kinds,
// ALU and immediate-extension op codes, and the fetch sequencer states.
// Also provides the 16-bit sign-extension helper used by next-PC logic.
package fetch_unit_pkg;

  // Default fetch start address; the low two bits must stay zero.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Decoder branch kind. The unused code 2'b11 behaves like BR_NONE.
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } branch_e;

  // ALU operation codes driven by the control decoder.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  // Immediate extension modes.
  typedef enum logic [1:0] {
    EXT_ZERO = 2'd0,
    EXT_SIGN = 2'd1,
    EXT_LUI  = 2'd2
  } ext_op_e;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Bundles the instruction-memory handshake, the decoder-facing instruction
// outputs and the retirement/flow-control inputs of the fetch unit.
//   master : fetch_unit side (drives imem_req/addr, instr, pc, ...)
//   slave  : memory/decoder/datapath side (drives ack, rdata, retire, ...)
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [31:0] pc;
  logic        retire;
  logic        jump;
  logic [1:0]  Branch;
  logic        zero;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, OpCode, Funct, pc,
    input  imem_ack, imem_rdata, retire, jump, Branch, zero
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, OpCode, Funct, pc,
    output imem_ack, imem_rdata, retire, jump, Branch, zero
  );

endinterface

// File: rtl/fetch_unit_npc.sv
// fetch_unit_npc
// Purely combinational next-PC selection.
//   pc     in  32  address of the retiring instruction
//   instr  in  32  the retiring instruction word
//   jump   in  1   unconditional jump (highest priority)
//   Branch in  2   branch kind (see branch_e)
//   zero   in  1   ALU equal-zero flag
//   npc    out 32  next PC, word aligned
module fetch_unit_npc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic [1:0]  Branch,
  input  logic        zero,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] jump_target;
  logic        br_taken;
  logic [31:0] sel_next;

  // All adds wrap modulo 2^32.
  assign pc_plus4    = pc + 32'd4;
  assign br_offset   = sext16(instr[15:0]) << 2;
  assign br_target   = pc_plus4 + br_offset;
  assign jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};

  // 2'b11 is deliberately not matched, so it falls through as "no branch".
  assign br_taken = ((Branch == BR_EQ) &&  zero) ||
                    ((Branch == BR_NE) && !zero);

  always_comb begin
    sel_next = pc_plus4;
    if (jump) begin
      sel_next = jump_target;
    end else if (br_taken) begin
      sel_next = br_target;
    end
  end

  assign npc = {sel_next[31:2], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch and sequencing unit. Holds the PC, fetches one word at a
// time over a req/ack handshake, presents it to the decoder and waits for the
// datapath to retire it before computing and loading the next PC.
//   clk  in  1  system clock, rising edge
//   rst  in  1  asynchronous active-high reset
//   bus  fetch_unit_if.master  memory handshake, instruction outputs,
//        retire and flow-control inputs
// Parameter RESET_PC: PC loaded on reset (low two bits are ignored).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  instr_reg;
  logic         valid_reg;
  logic         req_reg;
  logic [31:0]  pc_next;

  fetch_unit_npc u_npc (
    .pc     (pc_reg),
    .instr  (instr_reg),
    .jump   (bus.jump),
    .Branch (bus.Branch),
    .zero   (bus.zero),
    .npc    (pc_next)
  );

  // All outputs come straight from registers, so ack/retire never reach an
  // output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC_ALIGNED;
      instr_reg <= 32'd0;
      valid_reg <= 1'b0;
      req_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // Ack is ignored here, so a stale ack straddling reset is harmless.
          state_reg <= S_FETCH;
          req_reg   <= 1'b1;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            instr_reg <= bus.imem_rdata;
            valid_reg <= 1'b1;
            req_reg   <= 1'b0;
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.retire) begin
            pc_reg    <= pc_next;
            valid_reg <= 1'b0;
            req_reg   <= 1'b1;
            state_reg <= S_FETCH;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          valid_reg <= 1'b0;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_reg;
  assign bus.imem_addr   = pc_reg;
  assign bus.pc          = pc_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_valid = valid_reg;
  assign bus.OpCode      = instr_reg[31:26];
  assign bus.Funct       = instr_reg[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed stimulus with a scoreboard: expected fetch addresses and issued
// instructions are queued by the stimulus and checked by a separate monitor
// whenever the DUT raises imem_req or instr_valid.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic wrst;

  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if wbus ();

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk (clk),
    .rst (wrst),
    .bus (wbus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr [$];
  logic [63:0] exp_instr [$];   // {pc, instr}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each new request and each new issue.
  initial begin
    logic prev_req;
    logic prev_valid;
    logic [63:0] e;
    prev_req   = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req   = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (bus.imem_req && !prev_req) begin
          if (exp_addr.size() == 0) begin
            chk("unexpected_fetch", bus.imem_addr, 32'hxxxx_xxxx);
          end else begin
            chk("fetch_addr", bus.imem_addr, exp_addr.pop_front());
          end
        end
        if (bus.instr_valid && !prev_valid) begin
          if (exp_instr.size() == 0) begin
            chk("unexpected_issue", bus.instr, 32'hxxxx_xxxx);
          end else begin
            e = exp_instr.pop_front();
            $display("issue pc=%h instr=%h opcode=%h funct=%h",
                     bus.pc, bus.instr, bus.OpCode, bus.Funct);
            chk("issue_pc", bus.pc, e[63:32]);
            chk("issue_instr", bus.instr, e[31:0]);
            chk("issue_opcode", 32'(bus.OpCode), 32'(e[31:26]));
            chk("issue_funct", 32'(bus.Funct), 32'(e[5:0]));
          end
        end
        prev_req   = bus.imem_req;
        prev_valid = bus.instr_valid;
      end
    end
  end

  task automatic wait_req();
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(bus.imem_req), 32'd1);
  endtask

  // Hold ack low for 'delay' FETCH cycles, then acknowledge with 'data'.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int delay);
    wait_req();
    for (int i = 0; i < delay; i++) begin
      chk("addr_hold", bus.imem_addr, addr);
      chk("req_hold", 32'(bus.imem_req), 32'd1);
      @(negedge clk);
    end
    chk("addr_at_ack", bus.imem_addr, addr);
    exp_instr.push_back({addr, data});
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0BAD_0BAD;
    chk("fetch_valid", 32'(bus.instr_valid), 32'd1);
    chk("fetch_req_drop", 32'(bus.imem_req), 32'd0);
  endtask

  // Retire with the given flow-control flags; junk flags are left driven
  // afterwards to show they are ignored without retire.
  task automatic retire_op(input logic j, input logic [1:0] br, input logic z,
                           input logic [31:0] next);
    exp_addr.push_back(next);
    bus.retire = 1'b1;
    bus.jump   = j;
    bus.Branch = br;
    bus.zero   = z;
    @(negedge clk);
    bus.retire = 1'b0;
    bus.jump   = 1'b1;
    bus.Branch = BR_EQ;
    bus.zero   = 1'b1;
    chk("next_pc", bus.pc, next);
    chk("valid_cleared", 32'(bus.instr_valid), 32'd0);
    chk("req_after_retire", 32'(bus.imem_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst  = 1'b1;
    wrst = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.retire     = 1'b0;
    bus.jump       = 1'b0;
    bus.Branch     = BR_NONE;
    bus.zero       = 1'b0;
    wbus.imem_ack   = 1'b0;
    wbus.imem_rdata = 32'd0;
    wbus.retire     = 1'b0;
    wbus.jump       = 1'b0;
    wbus.Branch     = BR_NONE;
    wbus.zero       = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("reset_pc", bus.pc, 32'h0000_3000);
    chk("reset_instr", bus.instr, 32'd0);
    chk("reset_valid", 32'(bus.instr_valid), 32'd0);
    chk("reset_req", 32'(bus.imem_req), 32'd0);

    // First fetch: ori, ack after 3 cycles
    exp_addr.push_back(32'h0000_3000);
    rst = 1'b0;
    fetch(32'h0000_3000, 32'h3408_0005, 3);
    chk("ori_opcode", 32'(bus.OpCode), 32'h0000_000D);

    // Ack during ISSUE must not disturb the held instruction
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("ack_ignored_instr", bus.instr, 32'h3408_0005);
    chk("ack_ignored_valid", 32'(bus.instr_valid), 32'd1);

    // Sequential retire
    retire_op(1'b0, BR_NONE, 1'b0, 32'h0000_3004);

    // Retire during FETCH is ignored
    bus.retire = 1'b1;
    @(negedge clk);
    bus.retire = 1'b0;
    chk("retire_ignored_pc", bus.pc, 32'h0000_3004);
    chk("retire_ignored_req", 32'(bus.imem_req), 32'd1);

    // bne taken, offset 4: 3004 + 20
    fetch(32'h0000_3004, 32'h1400_0004, 1);
    retire_op(1'b0, BR_NE, 1'b0, 32'h0000_3018);
    // j to 3010
    fetch(32'h0000_3018, 32'h0800_0C04, 0);
    retire_op(1'b1, BR_NONE, 1'b0, 32'h0000_3010);
    // beq taken, offset -4
    fetch(32'h0000_3010, 32'h1000_FFFC, 2);
    retire_op(1'b0, BR_EQ, 1'b1, 32'h0000_3004);
    // back to 3010
    fetch(32'h0000_3004, 32'h0800_0C04, 0);
    retire_op(1'b1, BR_NONE, 1'b0, 32'h0000_3010);
    // beq not taken
    fetch(32'h0000_3010, 32'h1000_FFFC, 0);
    retire_op(1'b0, BR_EQ, 1'b0, 32'h0000_3014);
    // jump wins over a taken branch
    fetch(32'h0000_3014, 32'h0800_0C10, 1);
    retire_op(1'b1, BR_EQ, 1'b1, 32'h0000_3040);

    // Async reset mid-fetch
    wait_req();
    chk("pre_reset_addr", bus.imem_addr, 32'h0000_3040);
    #2 rst = 1'b1;
    #1;
    chk("async_req", 32'(bus.imem_req), 32'd0);
    chk("async_pc", bus.pc, 32'h0000_3000);
    chk("async_valid", 32'(bus.instr_valid), 32'd0);
    chk("async_instr", bus.instr, 32'd0);
    @(negedge clk);
    exp_addr.push_back(32'h0000_3000);
    rst = 1'b0;
    bus.imem_ack   = 1'b1;   // lands in IDLE, must be ignored
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("idle_ack_valid", 32'(bus.instr_valid), 32'd0);
    chk("idle_ack_instr", bus.instr, 32'd0);
    chk("restart_req", 32'(bus.imem_req), 32'd1);
    fetch(32'h0000_3000, 32'h2008_0001, 0);
    retire_op(1'b0, BR_NONE, 1'b1, 32'h0000_3004);

    // Wrap-around on the second instance
    wrst = 1'b0;
    n = 0;
    while (wbus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_req", 32'(wbus.imem_req), 32'd1);
    chk("wrap_addr", wbus.imem_addr, 32'hFFFF_FFFC);
    wbus.imem_ack   = 1'b1;
    wbus.imem_rdata = 32'h0000_0000;
    @(negedge clk);
    wbus.imem_ack = 1'b0;
    chk("wrap_valid", 32'(wbus.instr_valid), 32'd1);
    $display("issue pc=%h instr=%h (wrap instance)", wbus.pc, wbus.instr);
    wbus.retire = 1'b1;
    @(negedge clk);
    wbus.retire = 1'b0;
    chk("wrap_next_pc", wbus.pc, 32'h0000_0000);
    chk("wrap_next_req", 32'(wbus.imem_req), 32'd1);

    @(negedge clk);
    chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk("instr_queue_empty", 32'(exp_instr.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
